// File: rtl/vend_sequencer.sv
// vend_sequencer: front-panel sequencing controller for the vending datapath.
// Collects coins into a single registered credit value, grants one product
// at a time from a round-robin arbiter over the four Buy buttons, supervises
// the dispenser handshake with a timeout, and pays change out as nickels.
module vend_sequencer #(
    parameter int Cost0         = 5,
    parameter int Cost1         = 10,
    parameter int Cost2         = 15,
    parameter int Cost3         = 30,
    parameter int MaxCredit     = 95,
    parameter int TimeoutCycles = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       nickel,
    input  logic       dime,
    input  logic       quarter,
    input  logic [3:0] buy,
    input  logic       refund,
    input  logic       disp_done,
    output logic [6:0] money,
    output logic [3:0] vending,
    output logic       nickel_out,
    output logic       coin_reject,
    output logic       fault,
    output logic       busy
);

    // The timer only has to count 0 .. TimeoutCycles-1; the abort decision is
    // taken in the cycle where it sits on its last value.
    localparam int TimerW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TimeoutCycles - 1);
    localparam logic [7:0] MaxCredit8 = 8'(MaxCredit);
    localparam logic [6:0] NickelValue = 7'd5;
    localparam logic [6:0] DimeValue = 7'd10;
    localparam logic [6:0] QuarterValue = 7'd25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [6:0]        money_d;
    logic [3:0]        vending_d;
    logic              nickel_out_d;
    logic              coin_reject_d;
    logic              fault_d;
    logic [TimerW-1:0] timer, timer_d;
    logic [1:0]        ptr, ptr_d;

    logic [1:0]        coin_count;
    logic              any_coin;
    logic              multi_coin;
    logic [6:0]        coin_value;
    logic [7:0]        credit_sum;
    logic              coin_fits;

    logic [3:0]        eligible;
    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic [3:0]        grant_onehot;

    // Price of a product by index.
    function automatic logic [6:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = 7'(Cost0);
            2'd1:    price_of = 7'(Cost1);
            2'd2:    price_of = 7'(Cost2);
            default: price_of = 7'(Cost3);
        endcase
    endfunction

    // Price of whatever is currently being vended, used to restore credit
    // when the dispenser never answers.
    function automatic logic [6:0] vend_cost(input logic [3:0] onehot);
        case (onehot)
            4'b0001: vend_cost = price_of(2'd0);
            4'b0010: vend_cost = price_of(2'd1);
            4'b0100: vend_cost = price_of(2'd2);
            4'b1000: vend_cost = price_of(2'd3);
            default: vend_cost = 7'd0;
        endcase
    endfunction

    // Coin decode: count simultaneous pulses and check whether a lone coin
    // still fits under the credit ceiling (9-bit-free sum avoids wrap).
    always_comb begin
        coin_count = {1'b0, nickel} + {1'b0, dime} + {1'b0, quarter};
        any_coin   = nickel | dime | quarter;
        multi_coin = coin_count > 2'd1;
        coin_value = 7'd0;
        if (nickel) begin
            coin_value = NickelValue;
        end
        if (dime) begin
            coin_value = DimeValue;
        end
        if (quarter) begin
            coin_value = QuarterValue;
        end
        credit_sum = {1'b0, money} + {1'b0, coin_value};
        coin_fits  = credit_sum <= MaxCredit8;
    end

    // A request is only a candidate when the credit covers its price.
    always_comb begin
        eligible = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            eligible[i] = buy[i] && (money >= price_of(2'(i)));
        end
    end

    // Round-robin arbiter: scan from the pointer upward, wrapping 3 -> 0.
    // Scanning offsets from high to low lets the nearest candidate win.
    always_comb begin
        logic [1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = ptr;
        cand        = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_onehot = 4'b0001 << grant_idx;
    end

    // Next-state and next-output logic; every output is registered, so this
    // block computes the values the registers take on the next edge.
    always_comb begin
        state_d       = state;
        money_d       = money;
        vending_d     = vending;
        nickel_out_d  = 1'b0;
        coin_reject_d = 1'b0;
        fault_d       = 1'b0;
        timer_d       = timer;
        ptr_d         = ptr;

        case (state)
            IDLE: begin
                vending_d = 4'b0000;
                if (grant_valid) begin
                    state_d       = VEND;
                    vending_d     = grant_onehot;
                    money_d       = money - price_of(grant_idx);
                    ptr_d         = grant_idx + 2'd1;
                    timer_d       = '0;
                    coin_reject_d = any_coin;
                end else if (refund && (money != 7'd0)) begin
                    state_d       = CHANGE;
                    coin_reject_d = any_coin;
                end else if (multi_coin) begin
                    coin_reject_d = 1'b1;
                end else if (any_coin) begin
                    if (coin_fits) begin
                        money_d = credit_sum[6:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            VEND: begin
                coin_reject_d = any_coin;
                if (disp_done) begin
                    state_d   = IDLE;
                    vending_d = 4'b0000;
                    timer_d   = '0;
                end else if (timer == TimeoutLast) begin
                    state_d   = IDLE;
                    vending_d = 4'b0000;
                    money_d   = money + vend_cost(vending);
                    fault_d   = 1'b1;
                    timer_d   = '0;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end

            CHANGE: begin
                coin_reject_d = any_coin;
                if (money == 7'd0) begin
                    state_d = IDLE;
                end else begin
                    nickel_out_d = 1'b1;
                    money_d      = money - NickelValue;
                    if (money == NickelValue) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                vending_d = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset discards any credit on purpose.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            money       <= 7'd0;
            vending     <= 4'b0000;
            nickel_out  <= 1'b0;
            coin_reject <= 1'b0;
            fault       <= 1'b0;
            timer       <= '0;
            ptr         <= 2'd0;
        end else begin
            state       <= state_d;
            money       <= money_d;
            vending     <= vending_d;
            nickel_out  <= nickel_out_d;
            coin_reject <= coin_reject_d;
            fault       <= fault_d;
            timer       <= timer_d;
            ptr         <= ptr_d;
        end
    end

    assign busy = (state != IDLE);

endmodule
